// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Purpose:
//   Micro-sequencer that produces the 16-bit Datapath control word.
//   A pass goes through these phases:
//     LOAD  : loads NUM_OPS operands from Data_in into R0..R(NUM_OPS-1).
//             Each step pulse advances to the next register.
//     EXEC  : folds the operands into ACC_REG with the operation chosen by
//             op_sel. This takes NUM_OPS-1 automatic cycles.
//     DONE  : holds ACC_REG on the Datapath output for display.
//     CLEAR : zeroes ACC_REG, then starts the next LOAD pass.
//   IDLE is entered only by reset and is left only by step.
//
// Parameters:
//   NUM_OPS  number of operands per pass (2..7)
//   ACC_REG  accumulator register address (NUM_OPS..7)
//
// Ports:
//   clk           system clock
//   reset_b       asynchronous, active-low reset
//   step          one-cycle pulse from the debouncer; advances the sequence
//   op_sel[2:0]   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 ADD
//   ovf_in        Datapath V flag
//   control_word  {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}
//   state_o[2:0]  current state code (0 IDLE, 1 LOAD, 2 EXEC, 3 DONE, 4 CLEAR)
//   op_idx[2:0]   operand index in LOAD, execute index in EXEC, otherwise 0
//   busy          high in EXEC and CLEAR
//   done          high in DONE
//   ovf_sticky    sticky overflow flag for the current pass
//
// Build option:
//   CTRL_SEQ_OVF_STICKY_EN
//     Defined: ovf_sticky captures ovf_in at the edge that ends any EXEC
//     cycle. The flag is cleared on entry to CLEAR.
//     Undefined: ovf_sticky is tied to 0 and ovf_in is unused.
//
// All outputs are registered. Each output register is loaded from the
// next-state values, so control_word always matches the state code on the
// same cycle.
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int NUM_OPS = 2,
    parameter int ACC_REG = 7
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        step,
    input  logic [2:0]  op_sel,
    input  logic        ovf_in,
    output logic [15:0] control_word,
    output logic [2:0]  state_o,
    output logic [2:0]  op_idx,
    output logic        busy,
    output logic        done,
    output logic        ovf_sticky
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    generate
        if (NUM_OPS < 2 || NUM_OPS > 7 || ACC_REG < NUM_OPS || ACC_REG > 7) begin : g_bad_params
            $fatal(1, "control_sequencer: need 2 <= NUM_OPS <= ACC_REG <= 7");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State codes
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    // ------------------------------------------------------------------
    // Function-select codes understood by the Datapath
    // ------------------------------------------------------------------
    localparam logic [3:0] FS_MOVA = 4'b0000;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_SUB  = 4'b0101;
    localparam logic [3:0] FS_AND  = 4'b1000;
    localparam logic [3:0] FS_OR   = 4'b1001;
    localparam logic [3:0] FS_XOR  = 4'b1010;
    localparam logic [3:0] FS_MOVB = 4'b1100;

    localparam logic [2:0] LAST_IDX = 3'(NUM_OPS - 1);
    localparam logic [2:0] ACC_ADDR = 3'(ACC_REG);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] fs_for_op(input logic [2:0] op);
        logic [3:0] fs;
        case (op)
            3'd1:    fs = FS_SUB;
            3'd2:    fs = FS_AND;
            3'd3:    fs = FS_OR;
            3'd4:    fs = FS_XOR;
            default: fs = FS_ADD;   // 0 and the unused codes 5-7
        endcase
        return fs;
    endfunction

    function automatic logic [15:0] pack_word(
        input logic [2:0] da,
        input logic [2:0] aa,
        input logic [2:0] ba,
        input logic       mb,
        input logic [3:0] fs,
        input logic       md,
        input logic       rw
    );
        return {da, aa, ba, mb, fs, md, rw};
    endfunction

    // Control word for a given (state, index, latched op).
    // The result depends only on the state the machine is entering, so
    // registering it keeps the outputs a clean Moore function.
    function automatic logic [15:0] word_for(
        input logic [2:0] st,
        input logic [2:0] idx,
        input logic [2:0] op
    );
        logic [15:0] w;
        case (st)
            // Rk <- Data_in, written every cycle while the user sets up the value
            S_LOAD:  w = pack_word(idx, idx, idx, 1'b0, FS_MOVA, 1'b1, 1'b1);
            // ACC <- (first cycle ? R0 : ACC) op Rj
            S_EXEC:  w = pack_word(ACC_ADDR,
                                   (idx == 3'd1) ? 3'd0 : ACC_ADDR,
                                   idx, 1'b0, fs_for_op(op), 1'b0, 1'b1);
            // Drive ACC onto the function output without writing anything
            S_DONE:  w = pack_word(ACC_ADDR, ACC_ADDR, ACC_ADDR,
                                   1'b0, FS_MOVA, 1'b0, 1'b0);
            // ACC <- constant_in, which is tied to zero at top level
            S_CLEAR: w = pack_word(ACC_ADDR, ACC_ADDR, 3'd0,
                                   1'b1, FS_MOVB, 1'b0, 1'b1);
            default: w = 16'h0000;  // IDLE and illegal codes
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  state_q,  state_d;
    logic [2:0]  idx_q,    idx_d;
    logic [2:0]  op_q,     op_d;
    logic [15:0] cw_q,     cw_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        sticky_q, sticky_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                if (step) begin
                    state_d = S_LOAD;
                    idx_d   = 3'd0;
                end
            end

            S_LOAD: begin
                if (step) begin
                    if (idx_q == LAST_IDX) begin
                        // Latch op_sel once per pass.
                        // Later changes wait until the next pass.
                        state_d = S_EXEC;
                        idx_d   = 3'd1;
                        op_d    = op_sel;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            // Self-timed: every EXEC cycle is exactly one clock and step is
            // deliberately not looked at here.
            S_EXEC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            S_DONE: begin
                if (step) begin
                    state_d = S_CLEAR;
                    idx_d   = 3'd0;
                end
            end

            S_CLEAR: begin
                state_d = S_LOAD;
                idx_d   = 3'd0;
            end

            default: begin
                // Unreachable codes 5-7 recover to IDLE on the next edge.
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered-output logic, computed from the next state
    // ------------------------------------------------------------------
    always_comb begin
        cw_d   = word_for(state_d, idx_d, op_d);
        busy_d = (state_d == S_EXEC) || (state_d == S_CLEAR);
        done_d = (state_d == S_DONE);
    end

`ifdef CTRL_SEQ_OVF_STICKY_EN
    always_comb begin
        sticky_d = sticky_q;
        // Capture the V flag produced by the EXEC cycle now ending.
        if (state_q == S_EXEC && ovf_in) begin
            sticky_d = 1'b1;
        end
        // The flag is cleared when CLEAR starts, so each pass reports
        // only its own overflow.
        if (state_d == S_CLEAR) begin
            sticky_d = 1'b0;
        end
    end
`else
    logic unused_ovf_in;
    assign unused_ovf_in = ovf_in;

    always_comb begin
        sticky_d = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            op_q     <= 3'd0;
            cw_q     <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            cw_q     <= cw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sticky_q <= sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign control_word = cw_q;
    assign state_o      = state_q;
    assign op_idx       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Three sequencers are instantiated, with NUM_OPS = 2, 3 and 4 (ACC_REG = 7).
// Each one drives a small 8-bit Datapath model with an 8-entry register
// file. A behavioural model tracks each pass in terms of phase, index,
// latched operation and the captured operand list. The expected DONE
// result is the arithmetic fold of those operands. A compare process
// checks every output on each falling edge, and the directed scenarios
// also check literal words and results.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int NI = 3;

`ifdef CTRL_SEQ_OVF_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_b = 1'b1;
    logic [2:0]  op_sel;
    logic        step    [NI];
    logic [7:0]  data_in [NI];
    logic        ovf     [NI];
    logic [15:0] cw      [NI];
    logic [2:0]  st      [NI];
    logic [2:0]  idx     [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic        ovs     [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        control_sequencer #(.NUM_OPS(gi + 2), .ACC_REG(7)) u_dut (
            .clk          (clk),
            .reset_b      (reset_b),
            .step         (step[gi]),
            .op_sel       (op_sel),
            .ovf_in       (ovf[gi]),
            .control_word (cw[gi]),
            .state_o      (st[gi]),
            .op_idx       (idx[gi]),
            .busy         (busy[gi]),
            .done         (done[gi]),
            .ovf_sticky   (ovs[gi])
        );
    end

    // ---------------- Datapath model ----------------
    logic [7:0] rf   [NI][8];
    logic [8:0] dp_r [NI];
    logic [7:0] dp_f [NI];
    logic       dp_init;

    function automatic logic [8:0] dp_alu(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] f;
        logic       v;
        f = 8'h00;
        v = 1'b0;
        case (fs)
            4'b0000: f = a;
            4'b0010: begin f = a + b; v = (a[7] == b[7]) && (f[7] != a[7]); end
            4'b0101: begin f = a - b; v = (a[7] != b[7]) && (f[7] != a[7]); end
            4'b1000: f = a & b;
            4'b1001: f = a | b;
            4'b1010: f = a ^ b;
            4'b1100: f = b;
            default: f = 8'h00;
        endcase
        return {v, f};
    endfunction

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dp_r[i] = dp_alu(cw[i][5:2], rf[i][cw[i][12:10]],
                             cw[i][6] ? 8'h00 : rf[i][cw[i][9:7]]);
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dp_f[i] = dp_r[i][7:0];
            ovf[i]  = dp_r[i][8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dp_init) begin
                for (int j = 0; j < 8; j++) rf[i][j] <= 8'h00;
            end else if (cw[i][0]) begin
                rf[i][cw[i][15:13]] <= cw[i][1] ? data_in[i] : dp_f[i];
            end
        end
    end

    // ---------------- Behavioural model ----------------
    // Phase numbers are the documented state codes: 0 idle, 1 load,
    // 2 exec, 3 done, 4 clear.
    int         m_ph   [NI];
    int         m_k    [NI];
    logic [2:0] m_op   [NI];
    logic       m_stk  [NI];
    logic [7:0] m_opnd [NI][8];

    always @(posedge clk or negedge reset_b) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset_b) begin
                m_ph[i]  <= 0;
                m_k[i]   <= 0;
                m_op[i]  <= 3'd0;
                m_stk[i] <= 1'b0;
            end else begin
                case (m_ph[i])
                    0: if (step[i]) begin m_ph[i] <= 1; m_k[i] <= 0; end
                    1: if (step[i]) begin
                        m_opnd[i][m_k[i]] <= data_in[i];
                        if (m_k[i] == i + 1) begin
                            m_ph[i] <= 2; m_k[i] <= 1; m_op[i] <= op_sel;
                        end else begin
                            m_k[i] <= m_k[i] + 1;
                        end
                    end
                    2: begin
                        if (STICKY_EN && ovf[i]) m_stk[i] <= 1'b1;
                        if (m_k[i] == i + 1) m_ph[i] <= 3;
                        else                 m_k[i] <= m_k[i] + 1;
                    end
                    3: if (step[i]) begin m_ph[i] <= 4; m_stk[i] <= 1'b0; end
                    4: begin m_ph[i] <= 1; m_k[i] <= 0; end
                    default: m_ph[i] <= 0;
                endcase
            end
        end
    end

    function automatic logic [15:0] exp_word(input int ph, input int k, input logic [2:0] op);
        int fs;
        int w;
        case (op)
            3'd1:    fs = 5;
            3'd2:    fs = 8;
            3'd3:    fs = 9;
            3'd4:    fs = 10;
            default: fs = 2;
        endcase
        case (ph)
            1:       w = k * 8192 + k * 1024 + k * 128 + 2 + 1;
            2:       w = 7 * 8192 + ((k == 1) ? 0 : 7) * 1024 + k * 128 + fs * 4 + 1;
            3:       w = 7 * 8192 + 7 * 1024 + 7 * 128;
            4:       w = 7 * 8192 + 7 * 1024 + 64 + 12 * 4 + 1;
            default: w = 0;
        endcase
        return w[15:0];
    endfunction

    function automatic logic [7:0] exp_result(input int i);
        logic [7:0] acc;
        acc = m_opnd[i][0];
        for (int j = 1; j < i + 2; j++) begin
            case (m_op[i])
                3'd1:    acc = acc - m_opnd[i][j];
                3'd2:    acc = acc & m_opnd[i][j];
                3'd3:    acc = acc | m_opnd[i][j];
                3'd4:    acc = acc ^ m_opnd[i][j];
                default: acc = acc + m_opnd[i][j];
            endcase
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] @%0t: got 0x%0h, want 0x%0h", nm, i, $time, act, exp);
        end
    endtask

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("cw", i, 32'(cw[i]), 32'(exp_word(m_ph[i], m_k[i], m_op[i])));
            chk("state", i, 32'(st[i]), 32'(m_ph[i]));
            chk("busy", i, 32'(busy[i]), 32'(m_ph[i] == 2 || m_ph[i] == 4));
            chk("done", i, 32'(done[i]), 32'(m_ph[i] == 3));
            chk("sticky", i, 32'(ovs[i]), 32'(m_stk[i]));
            if (m_ph[i] <= 2) chk("idx", i, 32'(idx[i]), 32'(m_k[i]));
            if (m_ph[i] == 3) chk("result", i, 32'(dp_f[i]), 32'(exp_result(i)));
        end
    end

    // ---------------- Stimulus ----------------
    task automatic do_step(input int i, input logic [7:0] d);
        @(negedge clk);
        data_in[i] = d;
        step[i]    = 1'b1;
        @(negedge clk);
        step[i]    = 1'b0;
    endtask

    initial begin
        dp_init = 1'b1;
        op_sel  = 3'd0;
        for (int i = 0; i < NI; i++) begin
            step[i]    = 1'b0;
            data_in[i] = 8'h00;
        end
        #2 reset_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cw", 0, 32'(cw[0]), 32'h0);
        chk("rst_state", 1, 32'(st[1]), 32'h0);
        dp_init = 1'b0;
        reset_b = 1'b1;

        // NUM_OPS=2, ADD 5 + 3
        do_step(0, 8'd0);
        chk("A_load0", 0, 32'(cw[0]), 32'h0003);
        do_step(0, 8'd5);
        chk("A_load1", 0, 32'(cw[0]), 32'h2483);
        do_step(0, 8'd3);
        chk("A_exec", 0, 32'(cw[0]), 32'hE089);
        for (int c = 0; c < 8 && !done[0]; c++) @(negedge clk);
        chk("A_done", 0, 32'(done[0]), 32'h1);
        chk("A_donecw", 0, 32'(cw[0]), 32'hFF80);
        chk("A_result", 0, 32'(dp_f[0]), 32'd8);
        do_step(0, 8'd0);
        chk("A_clear", 0, 32'(cw[0]), 32'hFC71);
        @(negedge clk);
        chk("A_reload", 0, 32'(cw[0]), 32'h0003);
        chk("A_r7", 0, 32'(rf[0][7]), 32'h0);

        // NUM_OPS=3, SUB 9 - 2 - 4, with step/op_sel noise during EXEC
        op_sel = 3'd1;
        do_step(1, 8'd0);
        do_step(1, 8'd9);
        do_step(1, 8'd2);
        data_in[1] = 8'd4;
        step[1]    = 1'b1;
        @(negedge clk);
        chk("B_exec1", 1, 32'(cw[1]), 32'hE095);
        op_sel = 3'd4;
        @(negedge clk);
        chk("B_exec2", 1, 32'(cw[1]), 32'hFD15);
        @(negedge clk);
        step[1] = 1'b0;
        chk("B_done", 1, 32'(done[1]), 32'h1);
        chk("B_result", 1, 32'(dp_f[1]), 32'd3);
        do_step(1, 8'd0);
        chk("B_clear", 1, 32'(cw[1]), 32'hFC71);
        @(negedge clk);
        chk("B_reload", 1, 32'(cw[1]), 32'h0003);
        chk("B_r7", 1, 32'(rf[1][7]), 32'h0);

        // NUM_OPS=2, ADD 100 + 100 overflows signed 8-bit
        op_sel = 3'd0;
        do_step(0, 8'd100);
        do_step(0, 8'd100);
        @(negedge clk);
        chk("C_sticky", 0, 32'(ovs[0]), 32'(STICKY_EN));
        chk("C_result", 0, 32'(dp_f[0]), 32'd200);
        do_step(0, 8'd0);
        chk("C_clr_sticky", 0, 32'(ovs[0]), 32'h0);

        // NUM_OPS=4, reset in the middle of EXEC
        op_sel = 3'd2;
        do_step(2, 8'd0);
        do_step(2, 8'hF0);
        do_step(2, 8'h3C);
        do_step(2, 8'hFF);
        do_step(2, 8'h0F);
        chk("D_exec1", 2, 32'(cw[2]), 32'hE0A1);
        @(negedge clk);
        chk("D_busy", 2, 32'(busy[2]), 32'h1);
        #3 reset_b = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("D_async_cw", i, 32'(cw[i]), 32'h0);
            chk("D_async_state", i, 32'(st[i]), 32'h0);
            chk("D_async_busy", i, 32'(busy[i]), 32'h0);
            chk("D_async_done", i, 32'(done[i]), 32'h0);
        end
        @(negedge clk);
        reset_b = 1'b1;
        do_step(2, 8'd0);
        chk("D_restart_state", 2, 32'(st[2]), 32'h1);
        chk("D_restart_cw", 2, 32'(cw[2]), 32'h0003);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
